// File: rtl/if_stage_pipe.sv
// IF stage: PC register and IF/ID pipeline register, driven by the stall vector,
// with branch redirects held pending across PC stalls. Optional macro STALL_PERF_CNT_EN.
//
// state | meaning
// IDLE  | in/just out of reset, ROM disabled, PC parked at RESET_PC
// BOOT  | one cycle with ROM enabled at RESET_PC, PC not yet advancing
// RUN   | normal fetch, stall and redirect handling
module if_stage_pipe #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] inst_i,
  output logic [31:0] pc_o,
  output logic        ce_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles_o,
  output logic        redirect_lost_o
`endif
);

  typedef enum logic [1:0] {IDLE, BOOT, RUN} state_t;

  state_t      state_q, state_d;
  logic        ce_q, ce_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        lost_q, lost_d;
`endif

  // Upper stall bits belong to later stages.
  logic unused_stall;
  assign unused_stall = ^stall[5:3];

  always_comb begin
    state_d     = state_q;
    ce_d        = ce_q;
    pc_d        = pc_q;
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;
    id_pc_d     = id_pc_q;
    id_inst_d   = id_inst_q;
    id_valid_d  = id_valid_q;
`ifdef STALL_PERF_CNT_EN
    stall_cnt_d = stall_cnt_q;
    lost_d      = lost_q;
`endif
    case (state_q)
      IDLE: begin
        state_d = BOOT;
        ce_d    = 1'b1;
        pc_d    = RESET_PC;
      end
      BOOT: state_d = RUN;
      RUN: begin
        // A live branch outranks a pending one; pending redirects wait out the stall.
        if (stall[0]) begin
          if (branch_flag_i) begin
            pend_v_d    = 1'b1;
            pend_addr_d = branch_target_i;
          end
        end else if (branch_flag_i) begin
          pc_d     = branch_target_i;
          pend_v_d = 1'b0;
        end else if (pend_v_q) begin
          pc_d     = pend_addr_q;
          pend_v_d = 1'b0;
        end else begin
          pc_d = pc_q + 32'd4;
        end

        if (!stall[1]) begin
          id_pc_d    = pc_q;
          id_inst_d  = inst_i;
          id_valid_d = 1'b1;
        end else if (!stall[2]) begin
          id_pc_d    = 32'h0;
          id_inst_d  = NOP_INST;
          id_valid_d = 1'b0;
        end
`ifdef STALL_PERF_CNT_EN
        if (stall[0] && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
        if (stall[0] && branch_flag_i && pend_v_q) lost_d = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ce_q        <= 1'b0;
      pc_q        <= RESET_PC;
      pend_v_q    <= 1'b0;
      pend_addr_q <= 32'h0;
      id_pc_q     <= 32'h0;
      id_inst_q   <= NOP_INST;
      id_valid_q  <= 1'b0;
`ifdef STALL_PERF_CNT_EN
      stall_cnt_q <= 32'h0;
      lost_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ce_q        <= ce_d;
      pc_q        <= pc_d;
      pend_v_q    <= pend_v_d;
      pend_addr_q <= pend_addr_d;
      id_pc_q     <= id_pc_d;
      id_inst_q   <= id_inst_d;
      id_valid_q  <= id_valid_d;
`ifdef STALL_PERF_CNT_EN
      stall_cnt_q <= stall_cnt_d;
      lost_q      <= lost_d;
`endif
    end
  end

  assign pc_o       = pc_q;
  assign ce_o       = ce_q;
  assign id_pc_o    = id_pc_q;
  assign id_inst_o  = id_inst_q;
  assign id_valid_o = id_valid_q;
`ifdef STALL_PERF_CNT_EN
  assign stall_cycles_o  = stall_cnt_q;
  assign redirect_lost_o = lost_q;
`endif

endmodule

// File: tb/tb_if_stage_pipe.sv
// Bench for if_stage_pipe: directed scenarios plus random stall/branch traffic
// against a cycle-level reference model of the fetch stage.
module tb_if_stage_pipe;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall = 6'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic [31:0] inst_i;
  logic [31:0] pc_o;
  logic        ce_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cycles_o;
  logic        redirect_lost_o;
`endif

  int checks = 0;
  int failures = 0;

  // Model state
  int          m_boot;          // edges seen since reset release, saturating at 2
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];       // at most one outstanding redirect
  logic [31:0] m_id_pc;
  logic [31:0] m_id_inst;
  logic        m_id_valid;
  longint      m_stall_cnt;
  logic        m_lost;

  if_stage_pipe #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .inst_i(inst_i), .pc_o(pc_o), .ce_o(ce_o),
    .id_pc_o(id_pc_o), .id_inst_o(id_inst_o), .id_valid_o(id_valid_o)
`ifdef STALL_PERF_CNT_EN
    , .stall_cycles_o(stall_cycles_o), .redirect_lost_o(redirect_lost_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign inst_i = rom(pc_o);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot = 0;
    m_pc = RESET_PC;
    m_pend.delete();
    m_id_pc = 32'h0;
    m_id_inst = NOP_INST;
    m_id_valid = 1'b0;
    m_stall_cnt = 0;
    m_lost = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":pc"}, pc_o, m_pc);
    chk({tag, ":ce"}, {31'b0, ce_o}, {31'b0, (m_boot != 0)});
    chk({tag, ":id_pc"}, id_pc_o, m_id_pc);
    chk({tag, ":id_inst"}, id_inst_o, m_id_inst);
    chk({tag, ":id_valid"}, {31'b0, id_valid_o}, {31'b0, m_id_valid});
`ifdef STALL_PERF_CNT_EN
    chk({tag, ":stall_cycles"}, stall_cycles_o, m_stall_cnt[31:0]);
    chk({tag, ":redirect_lost"}, {31'b0, redirect_lost_o}, {31'b0, m_lost});
`endif
  endtask

  // Drive one cycle's inputs (called at posedge+1), advance the model, check at next posedge+1.
  task automatic cycle(input logic [2:0] s, input logic bf, input logic [31:0] bt, input string tag);
    stall = {3'b000, s};
    branch_flag_i = bf;
    branch_target_i = bt;
    if (m_boot < 2) begin
      m_boot++;
    end else begin
      if (!s[1]) begin
        m_id_pc = m_pc;
        m_id_inst = rom(m_pc);
        m_id_valid = 1'b1;
      end else if (!s[2]) begin
        m_id_pc = 32'h0;
        m_id_inst = NOP_INST;
        m_id_valid = 1'b0;
      end
      if (s[0]) begin
        if (m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
        if (bf) begin
          if (m_pend.size() != 0) m_lost = 1'b1;
          m_pend.delete();
          m_pend.push_back(bt);
        end
      end else if (bf) begin
        m_pc = bt;
        m_pend.delete();
      end else if (m_pend.size() != 0) begin
        m_pc = m_pend.pop_front();
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b1;

    // Boot sequence: IDLE->BOOT, BOOT->RUN, then linear fetch
    cycle(3'b000, 1'b0, 32'h0, "boot");
    chk("boot_ce", {31'b0, ce_o}, 32'd1);
    chk("boot_pc", pc_o, 32'h0);
    cycle(3'b000, 1'b0, 32'h0, "run0");
    chk("run0_pc", pc_o, 32'h0);
    cycle(3'b000, 1'b0, 32'h0, "run1");
    chk("run1_pc", pc_o, 32'h4);
    chk("run1_id_pc", id_pc_o, 32'h0);
    chk("run1_id_valid", {31'b0, id_valid_o}, 32'd1);
    cycle(3'b000, 1'b0, 32'h0, "run2");
    chk("run2_id_pc", id_pc_o, 32'h4);
    repeat (2) cycle(3'b000, 1'b0, 32'h0, "run");
    chk("at_0x10", pc_o, 32'h10);

    // Full hold
    repeat (3) cycle(3'b111, 1'b0, 32'h0, "hold");
    chk("hold_pc", pc_o, 32'h10);
    cycle(3'b000, 1'b0, 32'h0, "hold_release");
    chk("release_pc", pc_o, 32'h14);

    // Bubble
    cycle(3'b011, 1'b0, 32'h0, "bubble");
    chk("bubble_inst", id_inst_o, NOP_INST);
    chk("bubble_valid", {31'b0, id_valid_o}, 32'd0);
    chk("bubble_pc", pc_o, 32'h14);

    // Pending redirect, last wins
    cycle(3'b000, 1'b1, 32'h20, "to_0x20");
    cycle(3'b111, 1'b1, 32'h100, "pend1");
    cycle(3'b111, 1'b1, 32'h200, "pend2");
    chk("pend_hold_pc", pc_o, 32'h20);
    cycle(3'b000, 1'b0, 32'h0, "pend_release");
    chk("pend_last_wins", pc_o, 32'h200);

    // Live branch beats pending
    cycle(3'b111, 1'b1, 32'h300, "pend3");
    cycle(3'b000, 1'b1, 32'h400, "live");
    chk("live_wins", pc_o, 32'h400);
    cycle(3'b000, 1'b0, 32'h0, "after_live");
    chk("pend_cleared", pc_o, 32'h404);

    // Wrap
    cycle(3'b000, 1'b1, 32'hFFFF_FFF8, "to_top");
    cycle(3'b000, 1'b0, 32'h0, "wrap1");
    chk("wrap_fffc", pc_o, 32'hFFFF_FFFC);
    cycle(3'b000, 1'b0, 32'h0, "wrap2");
    chk("wrap_zero", pc_o, 32'h0);

    // Async reset mid-stall with a redirect pending
    cycle(3'b111, 1'b1, 32'h500, "pend_pre_rst");
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst = 1'b1;
    repeat (3) cycle(3'b000, 1'b0, 32'h0, "post_rst");
    chk("no_stale_redirect", pc_o, 32'h4);

    // Random traffic, all stall combinations including the illegal ones
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  s;
      logic        bf;
      logic [31:0] bt;
      s  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      bf = ($urandom_range(0, 3) == 0);
      bt = $urandom();
      cycle(s, bf, bt, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
